// File: rtl/conveyor_scroll.sv
// conveyor_scroll: scrolling striped conveyor-belt overlay.
// A per-frame scroll offset is stepped by `speed` on qualifying frame ticks.
// Each pixel inside one of the stacked lanes is lit when its stripe phase
// falls in the lit part of the period. Odd lanes run the opposite way.
module conveyor_scroll #(
    parameter int COORD_W    = 16,
    parameter int PERIOD     = 64,
    parameter int STRIPE_ON  = 32,
    parameter int X_MIN      = 56,
    parameter int X_MAX      = 583,
    parameter int Y_MIN      = 400,
    parameter int LANE_H     = 16,
    parameter int LANE_PITCH = 32,
    parameter int LANES      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [COORD_W-1:0]          col,
    input  logic [COORD_W-1:0]          row,
    input  logic                        frame_tick,
    input  logic                        enable,
    input  logic                        dir,
    input  logic [3:0]                  speed,
    output logic                        swirl,
    output logic [1:0]                  lane_hit,
    output logic                        wrap,
    output logic [$clog2(PERIOD)-1:0]   offset
);

    localparam int OW = $clog2(PERIOD);

    localparam logic [COORD_W-1:0] XLO      = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] XHI      = COORD_W'(X_MAX);
    localparam logic [OW-1:0]      STRIPE_P = OW'(STRIPE_ON);

    logic [OW-1:0] spd_ext;
    logic [OW:0]   fwd_sum;
    logic          in_x;
    logic          hit;
    logic [1:0]    hit_lane;
    logic [OW-1:0] dxp;
    logic [OW-1:0] phase;
    logic          lit;

    // Step arithmetic; speed never reaches PERIOD, so one carry bit is enough.
    always_comb begin
        spd_ext = OW'(speed);
        fwd_sum = {1'b0, offset} + {1'b0, spd_ext};
    end

    // Scroll offset and wrap pulse: advance only on an enabled frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset <= '0;
            wrap   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (frame_tick && enable) begin
                if (!dir) begin
                    offset <= fwd_sum[OW-1:0];
                    wrap   <= fwd_sum[OW];
                end else begin
                    offset <= offset - spd_ext;
                    wrap   <= (spd_ext > offset);
                end
            end
        end
    end

    // Lane decode and stripe phase; the mod is plain truncation to OW bits.
    always_comb begin
        in_x     = (col >= XLO) && (col <= XHI);
        hit      = 1'b0;
        hit_lane = 2'd0;
        for (int k = 0; k < LANES; k++) begin
            if (in_x &&
                row >= COORD_W'(Y_MIN + k * LANE_PITCH) &&
                row <= COORD_W'(Y_MIN + k * LANE_PITCH + LANE_H - 1)) begin
                hit      = 1'b1;
                hit_lane = 2'(k);
            end
        end
        dxp   = col[OW-1:0] - XLO[OW-1:0];
        phase = hit_lane[0] ? (dxp - offset) : (dxp + offset);
        lit   = hit && (phase < STRIPE_P);
    end

    // Registered pixel outputs, one cycle behind col/row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swirl    <= 1'b0;
            lane_hit <= 2'd0;
        end else begin
            swirl    <= lit;
            lane_hit <= lit ? hit_lane : 2'd0;
        end
    end

endmodule

// File: tb/tb_conveyor_scroll.sv
// Bench for conveyor_scroll: a reference model computes each cycle's expected
// outputs from the belt rules, a monitor pops and compares them on negedge,
// and a few directed scenarios add checks against fixed values.
module tb_conveyor_scroll;

    localparam int P     = 64;
    localparam int XMIN  = 56;
    localparam int XMAX  = 583;
    localparam int YMIN  = 400;
    localparam int LH    = 16;
    localparam int LP    = 32;
    localparam int NL    = 2;
    localparam int SON   = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] col = '0;
    logic [15:0] row = '0;
    logic        frame_tick = 1'b0;
    logic        enable = 1'b0;
    logic        dir = 1'b0;
    logic [3:0]  speed = '0;
    logic        swirl;
    logic [1:0]  lane_hit;
    logic        wrap;
    logic [5:0]  offset;

    typedef struct {
        bit s;
        int ln;
        bit w;
        int off;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   m_off = 0;
    int   wrap_seen = 0;

    conveyor_scroll dut (
        .clk(clk), .rst_n(rst_n), .col(col), .row(row),
        .frame_tick(frame_tick), .enable(enable), .dir(dir), .speed(speed),
        .swirl(swirl), .lane_hit(lane_hit), .wrap(wrap), .offset(offset)
    );

    always #5 clk = ~clk;

    // Pixel rule: lane membership by rectangle, phase by modular arithmetic.
    function automatic void pix_model(input int c, input int r, input int off,
                                      output bit s, output int ln);
        s  = 1'b0;
        ln = 0;
        for (int k = 0; k < NL; k++) begin
            int top, ph;
            top = YMIN + k * LP;
            if (c >= XMIN && c <= XMAX && r >= top && r <= top + LH - 1) begin
                if (k % 2 == 0) ph = (c - XMIN + off) % P;
                else            ph = (((c - XMIN - off) % P) + P) % P;
                if (ph < SON) begin
                    s  = 1'b1;
                    ln = k;
                end
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Apply one cycle of stimulus; the expectation for that clock edge is queued.
    task automatic step(input int c, input int r, input bit tk, input bit en,
                        input bit d, input int sp);
        exp_t e;
        col = 16'(c); row = 16'(r); frame_tick = tk; enable = en;
        dir = d; speed = 4'(sp);
        @(posedge clk);
        pix_model(c, r, m_off, e.s, e.ln);
        e.w = 1'b0;
        if (tk && en) begin
            if (!d) begin
                e.w   = (m_off + sp >= P);
                m_off = (m_off + sp) % P;
            end else begin
                e.w   = (sp > m_off);
                m_off = (m_off - sp + P) % P;
            end
        end
        e.off = m_off;
        q.push_back(e);
        #1 frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        m_off = 0;
        q.delete();
        frame_tick = 1'b1; enable = 1'b1; speed = 4'd5;
        repeat (2) @(posedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: compare each queued expectation with the registered outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                total++;
                if (swirl != e.s || int'(lane_hit) != e.ln || wrap != e.w ||
                    int'(offset) != e.off) begin
                    bad++;
                    $display("FAIL scoreboard: got swirl=%0d lane=%0d wrap=%0d off=%0d expected swirl=%0d lane=%0d wrap=%0d off=%0d",
                             swirl, lane_hit, wrap, offset, e.s, e.ln, e.w, e.off);
                end
                if (wrap) wrap_seen++;
            end
        end
    end

    initial begin
        int off0;
        do_reset();
        @(negedge clk);
        chk("reset_offset", int'(offset), 0);
        chk("reset_swirl", int'(swirl), 0);

        // Static pattern at offset 0
        step(56, 400, 0, 1, 0, 0);  @(negedge clk); chk("static_c56", int'(swirl), 1);
        chk("static_c56_lane", int'(lane_hit), 0);
        step(88, 400, 0, 1, 0, 0);  @(negedge clk); chk("static_c88", int'(swirl), 0);
        step(120, 400, 0, 1, 0, 0); @(negedge clk); chk("static_c120", int'(swirl), 1);

        // Boundaries
        step(55, 400, 0, 1, 0, 0);  @(negedge clk); chk("bound_c55", int'(swirl), 0);
        step(584, 400, 0, 1, 0, 0); @(negedge clk); chk("bound_c584", int'(swirl), 0);
        step(56, 399, 0, 1, 0, 0);  @(negedge clk); chk("bound_r399", int'(swirl), 0);
        step(56, 416, 0, 1, 0, 0);  @(negedge clk); chk("bound_r416", int'(swirl), 0);
        step(56, 448, 0, 1, 0, 0);  @(negedge clk); chk("bound_r448", int'(swirl), 0);

        // Forward wrap: 16 ticks of 4
        wrap_seen = 0;
        for (int i = 1; i <= 16; i++) begin
            step(56, 400, 1, 1, 0, 4);
            @(negedge clk);
            chk("fwd_offset", int'(offset), (4 * i) % 64);
        end
        chk("fwd_wrap_count", wrap_seen, 1);

        // Enable low: ticks ignored
        off0 = int'(offset);
        repeat (5) step(100, 410, 1, 0, 0, 7);
        @(negedge clk);
        chk("disabled_hold", int'(offset), off0);

        // Reverse wrap
        do_reset();
        step(56, 400, 1, 1, 1, 3); @(negedge clk);
        chk("rev_offset1", int'(offset), 61); chk("rev_wrap1", int'(wrap), 1);
        step(56, 400, 1, 1, 1, 3); @(negedge clk);
        chk("rev_offset2", int'(offset), 58); chk("rev_wrap2", int'(wrap), 0);

        // Counter-scroll at offset 8
        do_reset();
        step(56, 400, 1, 1, 0, 4);
        step(56, 400, 1, 1, 0, 4);
        step(56, 400, 0, 1, 0, 0); @(negedge clk); chk("cs_even", int'(swirl), 1);
        step(56, 432, 0, 1, 0, 0); @(negedge clk); chk("cs_odd_c56", int'(swirl), 0);
        step(64, 432, 0, 1, 0, 0); @(negedge clk); chk("cs_odd_c64", int'(swirl), 1);
        chk("cs_odd_lane", int'(lane_hit), 1);

        // Async reset from offset 20 with swirl lit
        do_reset();
        step(56, 400, 1, 1, 0, 10);
        step(56, 400, 1, 1, 0, 10);
        step(56, 400, 0, 1, 0, 0); @(negedge clk);
        chk("pre_rst_off", int'(offset), 20); chk("pre_rst_swirl", int'(swirl), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_off", int'(offset), 0); chk("async_swirl", int'(swirl), 0);
        chk("async_lane", int'(lane_hit), 0); chk("async_wrap", int'(wrap), 0);
        m_off = 0;
        q.delete();
        frame_tick = 1'b1; enable = 1'b1; speed = 4'd9;
        @(posedge clk); #1 frame_tick = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        step(56, 400, 1, 1, 0, 2); @(negedge clk);
        chk("post_rst_off", int'(offset), 2);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(40, 600), $urandom_range(390, 460),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
                 $urandom_range(0, 1), $urandom_range(0, 15));
        end
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
